updown_counter_param: RTL and testbench
=======================================

Name: updown_counter_param

Overview:
Parametrised up/down counter with a configurable modulus, step size, wrap or saturate mode, synchronous load, and boundary flags. It serves as the general-purpose counting primitive for timers, address generators and decade or BCD-style counters across the design. The counter runs on one clock and has an asynchronous active-low reset.

Parameters:
WIDTH, 8, counter width in bits (1..32)
MAX_VAL, 2**WIDTH-1, top value of the count range, which is 0..MAX_VAL; must satisfy 1 <= MAX_VAL <= 2**WIDTH-1
SATURATE, 0, boundary mode: 0 = wrap at the boundary, 1 = hold at the boundary

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
enable  input  1  count enable; 0 holds the value
direction  input  1  1 = count up, 0 = count down
step  input  WIDTH  increment or decrement per enabled cycle; legal range 0..MAX_VAL
load  input  1  synchronous load strobe
load_value  input  WIDTH  value loaded when load=1
counter_out  output  WIDTH  current count, registered
at_max  output  1  combinational; 1 when counter_out == MAX_VAL
at_min  output  1  combinational; 1 when counter_out == 0
bound_pulse  output  1  registered one-cycle pulse when the last update crossed or hit the boundary

Behaviour:
- Clock and reset: one clock domain (clk); reset is asynchronous, active-low (rst_n).
- Reset (rst_n=0, asynchronous): counter_out=0 and bound_pulse=0. at_min=1 and at_max=0 (at_max=1 only if MAX_VAL==0, which is illegal).
- Priority per rising edge: load > enable > hold.
- Load:
  - counter_out <= min(load_value, MAX_VAL); an out-of-range load clamps to MAX_VAL.
  - bound_pulse <= 0.
  - Takes effect regardless of enable and direction.
- Enabled count, up (enable=1, load=0, direction=1):
  - Compute sum = counter_out + step at WIDTH+1 bits, so there is no silent overflow.
  - If sum <= MAX_VAL: counter_out <= sum; bound_pulse <= 0.
  - Else, SATURATE=0: counter_out <= sum - (MAX_VAL+1) (modulo wrap); bound_pulse <= 1.
  - Else, SATURATE=1: counter_out <= MAX_VAL; bound_pulse <= 1.
- Enabled count, down (enable=1, load=0, direction=0):
  - If counter_out >= step: counter_out <= counter_out - step; bound_pulse <= 0.
  - Else, SATURATE=0: counter_out <= counter_out + (MAX_VAL+1) - step, computed at WIDTH+1 bits; bound_pulse <= 1.
  - Else, SATURATE=1: counter_out <= 0; bound_pulse <= 1.
- Saturate mode at the rail: counting into the rail while already at it (e.g. at MAX_VAL, up, step>0) holds the value and pulses bound_pulse=1 every such cycle.
- step=0 with enable=1: value holds and bound_pulse <= 0.
- step > MAX_VAL is illegal. The RTL must still produce an in-range result: step is treated as step mod (MAX_VAL+1). A simulation-only assertion flags it.
- enable=0 and load=0: counter_out holds; bound_pulse <= 0, so the pulse is exactly one cycle wide.
- Latency:
  - counter_out updates one cycle after the controlling inputs are sampled.
  - at_max and at_min follow counter_out with no additional latency.
  - bound_pulse is aligned with the counter_out update that caused it.
- Reset mid-count: asserting rst_n low clears state immediately, without waiting for a clock edge. The first edge after rst_n rises applies normal priority.
- Invariant: counter_out is never outside 0..MAX_VAL after reset.
- Default parameters (WIDTH=8, MAX_VAL=255, SATURATE=0, step=1) give plain 8-bit wrap-around up/down counter behaviour.

Test Plan:
1. Default parameters, step=1. Reset, then up for 256 cycles -> counter_out goes 0..255 then 0; bound_pulse=1 only on the 255->0 edge; at_max=1 while at 255. Then down for 1 cycle from 0 -> counter_out=255 and bound_pulse=1.
2. WIDTH=4, MAX_VAL=9, SATURATE=0. Up with step=3 from 0 -> 3, 6, 9, 2 (pulse on 2), 5. Down with step=4 from 2 -> 8 (pulse), 4, 0 (no pulse; at_min=1).
3. WIDTH=4, MAX_VAL=9, SATURATE=1. Load 8, then up with step=3 -> 9 (pulse), 9 (pulse), with at_max=1 held. Then down with step=5 -> 4, 0 (pulse), 0 (pulse).
4. Priority check, MAX_VAL=9. Apply load=1, load_value=12, enable=1, direction=1 in the same cycle -> counter_out=9 (clamped), bound_pulse=0, no increment.
5. Hold and step=0. Toggle enable=0 for 5 cycles at value 7 -> value stays 7 and bound_pulse=0. Then enable=1 with step=0 -> value stays 7.
6. Reset mid-operation. Pull rst_n low between clock edges while counting at 5 -> counter_out=0 immediately, before the next edge. Release rst_n, then up with step=1 -> 1 on the first edge.

Source files
------------

// File: rtl/updown_counter_param.sv
// Up/down modulo counter over 0..MAX_VAL with step, load, and wrap/saturate boundary handling.
// Latency: one cycle from sampled inputs to counter_out/bound_pulse; no backpressure, an update is taken every edge.
module updown_counter_param #(
  parameter int              WIDTH    = 8,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             direction,
  input  logic [WIDTH-1:0] step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] counter_out,
  output logic             at_max,
  output logic             at_min,
  output logic             bound_pulse
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("updown_counter_param: WIDTH must be in 1..32");
  end
  if (MAX_VAL == '0) begin : g_bad_max
    $error("updown_counter_param: MAX_VAL must be at least 1");
  end

  // All range arithmetic is one bit wider so MAX_VAL+1 and up-sums never overflow.
  localparam logic [WIDTH:0] MAX_EXT = {1'b0, MAX_VAL};
  localparam logic [WIDTH:0] MOD     = MAX_EXT + {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q;
  logic             pulse_q;
  logic [WIDTH-1:0] count_nxt;
  logic             pulse_nxt;
  logic [WIDTH:0]   cnt_ext;
  logic [WIDTH:0]   step_eff;
  logic [WIDTH:0]   sum;

  assign cnt_ext  = {1'b0, count_q};
  // Out-of-range steps fold back into the count range instead of escaping it.
  assign step_eff = {1'b0, step} % MOD;
  assign sum      = cnt_ext + step_eff;

  always_comb begin
    count_nxt = count_q;
    pulse_nxt = 1'b0;
    if (load) begin
      count_nxt = (load_value > MAX_VAL) ? MAX_VAL : load_value;
    end else if (enable) begin
      if (direction) begin
        if (sum <= MAX_EXT) begin
          count_nxt = WIDTH'(sum);
        end else begin
          pulse_nxt = 1'b1;
          count_nxt = SATURATE ? MAX_VAL : WIDTH'(sum - MOD);
        end
      end else begin
        if (cnt_ext >= step_eff) begin
          count_nxt = WIDTH'(cnt_ext - step_eff);
        end else begin
          pulse_nxt = 1'b1;
          count_nxt = SATURATE ? '0 : WIDTH'(cnt_ext + MOD - step_eff);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      count_q <= count_nxt;
      pulse_q <= pulse_nxt;
    end
  end

  assign counter_out = count_q;
  assign bound_pulse = pulse_q;
  assign at_max      = (count_q == MAX_VAL);
  assign at_min      = (count_q == '0);

  a_step_range : assert property (@(posedge clk) disable iff (!rst_n)
    (enable && !load) |-> (step <= MAX_VAL))
    else $error("updown_counter_param: step %0d exceeds MAX_VAL %0d", step, MAX_VAL);

  a_count_range : assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= MAX_VAL)
    else $error("updown_counter_param: count %0d outside range", count_q);

endmodule

// File: tb/tb_updown_counter_param.sv
// Three counter configurations driven by shared directed vectors, checked against an arithmetic model.
module tb_updown_counter_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0;
  logic       direction = 1'b0;
  logic       load = 1'b0;
  logic [7:0] step = 8'd0;
  logic [7:0] load_value = 8'd0;

  logic [7:0] c0;
  logic [3:0] c1, c2;
  logic [2:0] amx, amn, bp;

  int n_checks = 0;
  int n_errors = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  // 0: default 8-bit wrap, 1: mod-10 wrap, 2: mod-10 saturate
  updown_counter_param u_def (
    .clk(clk), .rst_n(rst_n), .enable(enable), .direction(direction),
    .step(step), .load(load), .load_value(load_value),
    .counter_out(c0), .at_max(amx[0]), .at_min(amn[0]), .bound_pulse(bp[0]));

  updown_counter_param #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .enable(enable), .direction(direction),
    .step(step[3:0]), .load(load), .load_value(load_value[3:0]),
    .counter_out(c1), .at_max(amx[1]), .at_min(amn[1]), .bound_pulse(bp[1]));

  updown_counter_param #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .enable(enable), .direction(direction),
    .step(step[3:0]), .load(load), .load_value(load_value[3:0]),
    .counter_out(c2), .at_max(amx[2]), .at_min(amn[2]), .bound_pulse(bp[2]));

  function automatic longint max_of(input int i);
    return (i == 0) ? 64'd255 : 64'd9;
  endfunction

  function automatic bit sat_of(input int i);
    return (i == 2);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the count range is a ring of MAX_VAL+1 values; the pulse marks leaving the range.
  longint m_cnt [3];
  bit     m_p   [3];

  always @(posedge clk or negedge rst_n) begin
    longint s, lv, m, n;
    bit     p;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_cnt[i] <= 0;
        m_p[i]   <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        m  = max_of(i);
        s  = (i == 0) ? longint'(step) : longint'(step[3:0]);
        lv = (i == 0) ? longint'(load_value) : longint'(load_value[3:0]);
        n  = m_cnt[i];
        p  = 1'b0;
        if (load) begin
          n = (lv > m) ? m : lv;
        end else if (enable && direction) begin
          p = (m_cnt[i] + s > m);
          n = (p && sat_of(i)) ? m : (m_cnt[i] + s) % (m + 1);
        end else if (enable) begin
          p = (s > m_cnt[i]);
          n = (p && sat_of(i)) ? 0 : (m_cnt[i] - s + m + 1) % (m + 1);
        end
        m_cnt[i] <= n;
        m_p[i]   <= p;
      end
    end
  end

  always @(negedge clk) begin
    logic [63:0] act;
    if (started) begin
      for (int i = 0; i < 3; i++) begin
        act = (i == 0) ? 64'(c0) : (i == 1) ? 64'(c1) : 64'(c2);
        chk($sformatf("cmp_cnt[%0d]", i), act, 64'(m_cnt[i]));
        chk($sformatf("cmp_at_max[%0d]", i), 64'(amx[i]), 64'(m_cnt[i] == max_of(i)));
        chk($sformatf("cmp_at_min[%0d]", i), 64'(amn[i]), 64'(m_cnt[i] == 0));
        chk($sformatf("cmp_pulse[%0d]", i), 64'(bp[i]), 64'(m_p[i]));
      end
    end
  end

  task automatic drive(input bit en, input bit dir, input int stp, input bit ld, input int lv);
    enable     = en;
    direction  = dir;
    step       = 8'(stp);
    load       = ld;
    load_value = 8'(lv);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses;
    int exp_up [5];
    int exp_up_p [5];
    #1 rst_n = 1'b0;
    started = 1'b1;
    #2;
    chk("rst_cnt_async", 64'(c0), 64'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_cnt", 64'(c0), 64'd0);
    chk("rst_at_min", 64'(amn[0]), 64'd1);
    chk("rst_at_max", 64'(amx[0]), 64'd0);
    chk("rst_pulse", 64'(bp[0]), 64'd0);

    // Plan 1: full 8-bit lap upward, then one step down through zero
    pulses = 0;
    for (int k = 1; k <= 256; k++) begin
      drive(1, 1, 1, 0, 0);
      if (bp[0]) pulses++;
      if (k == 255) begin
        chk("t1_cnt_255", 64'(c0), 64'd255);
        chk("t1_at_max", 64'(amx[0]), 64'd1);
        chk("t1_no_pulse_255", 64'(bp[0]), 64'd0);
      end
    end
    chk("t1_wrap_cnt", 64'(c0), 64'd0);
    chk("t1_wrap_pulse", 64'(bp[0]), 64'd1);
    chk("t1_pulse_count", 64'(pulses), 64'd1);
    drive(1, 0, 1, 0, 0);
    chk("t1_down_cnt", 64'(c0), 64'd255);
    chk("t1_down_pulse", 64'(bp[0]), 64'd1);

    // Plan 2: mod-10 wrap with step 3 up, then step 4 down
    drive(0, 0, 0, 1, 0);
    exp_up   = '{3, 6, 9, 2, 5};
    exp_up_p = '{0, 0, 0, 1, 0};
    for (int k = 0; k < 5; k++) begin
      drive(1, 1, 3, 0, 0);
      chk($sformatf("t2_up_cnt%0d", k), 64'(c1), 64'(exp_up[k]));
      chk($sformatf("t2_up_pulse%0d", k), 64'(bp[1]), 64'(exp_up_p[k]));
    end
    drive(0, 0, 0, 1, 2);
    drive(1, 0, 4, 0, 0);
    chk("t2_dn_cnt8", 64'(c1), 64'd8);
    chk("t2_dn_pulse8", 64'(bp[1]), 64'd1);
    drive(1, 0, 4, 0, 0);
    chk("t2_dn_cnt4", 64'(c1), 64'd4);
    drive(1, 0, 4, 0, 0);
    chk("t2_dn_cnt0", 64'(c1), 64'd0);
    chk("t2_dn_pulse0", 64'(bp[1]), 64'd0);
    chk("t2_at_min", 64'(amn[1]), 64'd1);

    // Plan 3: saturating rails
    drive(0, 0, 0, 1, 8);
    chk("t3_load8", 64'(c2), 64'd8);
    drive(1, 1, 3, 0, 0);
    chk("t3_sat_hi1", 64'(c2), 64'd9);
    chk("t3_sat_hi1_p", 64'(bp[2]), 64'd1);
    drive(1, 1, 3, 0, 0);
    chk("t3_sat_hi2", 64'(c2), 64'd9);
    chk("t3_sat_hi2_p", 64'(bp[2]), 64'd1);
    chk("t3_at_max", 64'(amx[2]), 64'd1);
    drive(1, 0, 5, 0, 0);
    chk("t3_dn4", 64'(c2), 64'd4);
    chk("t3_dn4_p", 64'(bp[2]), 64'd0);
    drive(1, 0, 5, 0, 0);
    chk("t3_sat_lo1", 64'(c2), 64'd0);
    chk("t3_sat_lo1_p", 64'(bp[2]), 64'd1);
    drive(1, 0, 5, 0, 0);
    chk("t3_sat_lo2", 64'(c2), 64'd0);
    chk("t3_sat_lo2_p", 64'(bp[2]), 64'd1);

    // Plan 4: load beats enable and clamps
    drive(1, 1, 1, 1, 12);
    chk("t4_clamp_wrap", 64'(c1), 64'd9);
    chk("t4_clamp_sat", 64'(c2), 64'd9);
    chk("t4_noclamp_def", 64'(c0), 64'd12);
    chk("t4_pulse", 64'(bp[1]), 64'd0);

    // Plan 5: hold and zero step
    drive(0, 0, 0, 1, 7);
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, 3, 0, 0);
      chk($sformatf("t5_hold%0d", k), 64'(c1), 64'd7);
      chk($sformatf("t5_hold_p%0d", k), 64'(bp[1]), 64'd0);
    end
    drive(1, 1, 0, 0, 0);
    chk("t5_step0_up", 64'(c1), 64'd7);
    drive(1, 0, 0, 0, 0);
    chk("t5_step0_dn", 64'(c2), 64'd7);
    chk("t5_step0_p", 64'(bp[2]), 64'd0);

    // Plan 6: asynchronous reset between edges
    drive(0, 0, 0, 1, 4);
    drive(1, 1, 1, 0, 0);
    chk("t6_pre", 64'(c1), 64'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_cnt", 64'(c1), 64'd0);
    chk("t6_async_def", 64'(c0), 64'd0);
    chk("t6_async_min", 64'(amn[1]), 64'd1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_first_edge", 64'(c1), 64'd1);
    chk("t6_first_edge_def", 64'(c0), 64'd1);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
